// File: rtl/regfile_mp_sp_if.sv
// Bundle of read, write, stack-op and status signals between the pipeline
// stages and the multi-port register file.
interface regfile_mp_sp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr0_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic [1:0]        sp_op;
    logic              flag_clr;
    logic [DATA_W-1:0] sp_out;
    logic              sp_ovf;
    logic              sp_unf;

    modport master (
        output rd_addr_a, rd_addr_b,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output sp_op, flag_clr,
        input  rd_data_a, rd_data_b, sp_out, sp_ovf, sp_unf
    );

    modport slave (
        input  rd_addr_a, rd_addr_b,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  sp_op, flag_clr,
        output rd_data_a, rd_data_b, sp_out, sp_ovf, sp_unf
    );
endinterface

// File: rtl/regfile_mp_sp.sv
// Two-read / two-write register file with an in-place stack-pointer unit,
// write-first read forwarding and sticky SP overflow/underflow flags.
module regfile_mp_sp #(
    parameter int                DATA_W   = 8,
    parameter int                NUM_REGS = 4,
    parameter int                SP_IDX   = NUM_REGS - 1,
    parameter logic [DATA_W-1:0] SP_RESET = '1
) (
    input logic              clk,
    input logic              rst,
    regfile_mp_sp_if.slave   rf
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [DATA_W-1:0] sp_cur;
    logic              sp_written;
    logic              push_req, pop_req;
    logic              push_do, pop_do;

    // Any explicit write to the SP register cancels the stack arithmetic,
    // including its flag side effects.
    always_comb begin
        sp_cur     = regs_q[SP_IDX];
        push_req   = (rf.sp_op == 2'b01);
        pop_req    = (rf.sp_op == 2'b10);
        sp_written = (rf.wr1_en && rf.wr1_addr == ADDR_W'(SP_IDX)) ||
                     (rf.wr0_en && rf.wr0_addr == ADDR_W'(SP_IDX));
        push_do    = push_req && !sp_written;
        pop_do     = pop_req && !sp_written;
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
            if (rf.wr1_en && rf.wr1_addr == ADDR_W'(r)) begin
                regs_d[r] = rf.wr1_data;
            end else if (rf.wr0_en && rf.wr0_addr == ADDR_W'(r)) begin
                regs_d[r] = rf.wr0_data;
            end else if (r == SP_IDX && push_req) begin
                regs_d[r] = sp_cur - DATA_W'(1);
            end else if (r == SP_IDX && pop_req) begin
                regs_d[r] = sp_cur + DATA_W'(1);
            end
        end
    end

    // A set in the same cycle as flag_clr wins over the clear.
    always_comb begin
        ovf_d = (push_do && sp_cur == '0) | (ovf_q & ~rf.flag_clr);
        unf_d = (pop_do && sp_cur == SP_RESET) | (unf_q & ~rf.flag_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= (r == SP_IDX) ? SP_RESET : '0;
            end
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Reads return the resolved next value; sp_out shows only stored state.
    assign rf.rd_data_a = regs_d[rf.rd_addr_a];
    assign rf.rd_data_b = regs_d[rf.rd_addr_b];
    assign rf.sp_out    = regs_q[SP_IDX];
    assign rf.sp_ovf    = ovf_q;
    assign rf.sp_unf    = unf_q;
endmodule
